// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the multi-channel clock divider.
// Contents:
//   NCH_DEF, CNT_W_DEF, DIV_RST_DEF : default channel count, counter width, reset divisor
//   ch_idx_w()                      : width of a channel index (minimum 1 bit)
package clk_div_pkg;

   localparam int unsigned NCH_DEF     = 4;
   localparam int unsigned CNT_W_DEF   = 32;
   localparam int unsigned DIV_RST_DEF = 12499;

   // Channel-index width; a single channel still needs a 1-bit select.
   function automatic int unsigned ch_idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active divisor, shadow divisor and pending flag.
// Optional feature macro: CLK_DIV_TICK_EN adds the registered tick output.
// Ports:
//   clk_in, rst_n  : clock, synchronous active-low reset
//   en             : channel enable (level)
//   sync_all       : clear counter/output and apply any pending shadow
//   wr, wr_div     : accepted load for this channel and its divisor
//   pending        : shadow divisor waiting to become active
//   divided_clk    : divided clock, period 2*(D+1)
//   tick           : one-cycle pulse with each rising divided_clk (CLK_DIV_TICK_EN only)
module clk_div_chan #(
   parameter int unsigned CNT_W   = 32,
   parameter int unsigned DIV_RST = 12499
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync_all,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   output logic             pending,
   output logic             divided_clk
`ifdef CLK_DIV_TICK_EN
   ,
   output logic             tick
`endif
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div;
   logic [CNT_W-1:0] shadow;
   // Enable seen on the previous edge; the enable edge itself only arms the counter.
   logic             en_q;

   // Counter, output toggle and shadow hand-over.
   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         cnt         <= '0;
         div         <= CNT_W'(DIV_RST);
         shadow      <= CNT_W'(DIV_RST);
         pending     <= 1'b0;
         divided_clk <= 1'b0;
         en_q        <= 1'b0;
`ifdef CLK_DIV_TICK_EN
         tick        <= 1'b0;
`endif
      end else begin
         en_q <= en;
`ifdef CLK_DIV_TICK_EN
         tick <= 1'b0;
`endif
         // Idle, freshly enabled or synchronised: hold at phase zero and
         // apply any waiting divisor immediately (no period to protect).
         if (sync_all || !en || !en_q) begin
            cnt         <= '0;
            divided_clk <= 1'b0;
            if (pending) begin
               div     <= shadow;
               pending <= 1'b0;
            end
         end else if (cnt == div) begin
            cnt         <= '0;
            divided_clk <= ~divided_clk;
`ifdef CLK_DIV_TICK_EN
            tick        <= ~divided_clk;
`endif
            // Swap divisors only on a half-period boundary so no runt appears.
            if (pending) begin
               div     <= shadow;
               pending <= 1'b0;
            end
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         // A load is only accepted when nothing is pending, so it never
         // collides with the hand-over above.
         if (wr) begin
            shadow  <= wr_div;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider with a shared divisor load port.
// Optional feature macro: CLK_DIV_TICK_EN adds the per-channel tick output.
// Ports:
//   clk_in, rst_n          : clock, synchronous active-low reset
//   chan_en[NCH]           : per-channel enable
//   sync_all               : phase-align all channels
//   load_valid/load_ch/load_div, load_ready : divisor update handshake
//   divided_clk[NCH]       : per-channel divided clocks
//   tick[NCH]              : per-channel rising-edge pulses (CLK_DIV_TICK_EN only)
module clk_div_multi
   import clk_div_pkg::*;
#(
   parameter int unsigned NCH     = NCH_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned DIV_RST = DIV_RST_DEF
) (
   input  logic                       clk_in,
   input  logic                       rst_n,
   input  logic [NCH-1:0]             chan_en,
   input  logic                       sync_all,
   input  logic                       load_valid,
   input  logic [ch_idx_w(NCH)-1:0]   load_ch,
   input  logic [CNT_W-1:0]           load_div,
   output logic                       load_ready,
   output logic [NCH-1:0]             divided_clk
`ifdef CLK_DIV_TICK_EN
   ,
   output logic [NCH-1:0]             tick
`endif
);

   localparam int unsigned LCH_W = ch_idx_w(NCH);

   logic [NCH-1:0] pending;
   logic [NCH-1:0] wr;

   // Load decode; an out-of-range channel reads ready and is dropped.
   always_comb begin
      load_ready = 1'b1;
      wr         = '0;
      for (int i = 0; i < NCH; i++) begin
         if (load_ch == LCH_W'(i)) begin
            load_ready = ~pending[i];
            wr[i]      = load_valid & ~pending[i];
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_chan
      clk_div_chan #(
         .CNT_W   (CNT_W),
         .DIV_RST (DIV_RST)
      ) u_chan (
         .clk_in      (clk_in),
         .rst_n       (rst_n),
         .en          (chan_en[g]),
         .sync_all    (sync_all),
         .wr          (wr[g]),
         .wr_div      (load_div),
         .pending     (pending[g]),
         .divided_clk (divided_clk[g])
`ifdef CLK_DIV_TICK_EN
         ,
         .tick        (tick[g])
`endif
      );
   end

endmodule
